param_counter: RTL and testbench
================================

# param_counter

Parametrised up/down counter that succeeds the fixed 3-bit free-running counter. It adds programmable width, a programmable terminal value, direction control, synchronous load, enable, wrap or saturate selection, a terminal-count pulse and a sticky overflow flag. It sits beside the timing and sequencing logic as a general-purpose event and interval counter.

## Interface
- WIDTH, 8, counter width in bits; must be at least 1.
- PRESCALE, 4, enabled cycles per count step; must be at least 1; used only when `PARAM_COUNTER_PRESCALE_EN` is defined.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  count enable, sampled on clk.
- up_dn  in  1  direction: 1 counts up, 0 counts down.
- sat  in  1  boundary mode: 1 saturates, 0 wraps.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- modulus  in  WIDTH  terminal value; the count range is 0..modulus.
- clr_ovf  in  1  clears the sticky overflow flag.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- ovf  out  1  sticky boundary-event flag, registered.

## Operation
- Priority per edge, highest first: reset, load, step, hold.
- Load:
  - count <= min(load_val, modulus).
  - No tc, no ovf change.
  - The prescaler, when compiled in, is cleared.
- Step (en=1 and a step is due), up:
  - count < modulus: count+1.
  - count >= modulus with sat=0: count <= 0.
  - count >= modulus with sat=1: count <= modulus.
- Step, down:
  - count > 0: count-1.
  - This includes count > modulus, which decrements normally.
  - count == 0 with sat=0: count <= modulus.
  - count == 0 with sat=1: count stays 0.
- Boundary event: any step taken from the boundary (up with count >= modulus, down with count == 0), whether it wraps or saturates.
  - tc <= 1 for exactly the next cycle.
  - ovf <= 1.
- Saturated counter with en held: a boundary event occurs on every step, so tc stays high continuously.
- modulus == 0:
  - Every step is a boundary event.
  - count stays 0.
- ovf:
  - Stays set until clr_ovf=1.
  - Simultaneous set and clr_ovf: set wins, ovf stays 1.
- modulus and up_dn may change on any cycle. Each step uses the values sampled on that edge.
- Arithmetic is unsigned, modulo 2^WIDTH internally. The comparisons above guarantee count never leaves 0..max(modulus, loaded value).

## Timing
- Reset (rst=0, asynchronous): count=0, tc=0, ovf=0, prescaler=0 immediately. The first count after release needs a rising edge with rst=1.
- Latency: en/load/clr_ovf sampled at edge N; count/tc/ovf reflect it after edge N.
- tc: high during the cycle following the boundary step; low otherwise.
- Reset mid-count or mid-pulse: all outputs drop at once, and any pending tc is lost.
- load and en together: load wins, no step, no tc.

## Configuration
- `PARAM_COUNTER_PRESCALE_EN` defined:
  - An internal prescaler counts enabled cycles 0..PRESCALE-1.
  - A step occurs only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - en=0 holds the prescaler.
  - load or reset clears it.
- Not defined: every enabled cycle is a step. PRESCALE is ignored, and no prescaler register exists.

## Test plan
- WIDTH=3, modulus=7, up_dn=1, sat=0, en=1 after reset release -> count 0,1,...,7,0; tc high one cycle after the 7->0 edge; ovf=1 and held.
- modulus=5, up_dn=0, sat=1, starting from load_val=2 -> count 2,1,0,0,0; tc high from the first 0->0 step onward while en stays high; ovf=1.
- load_val=6 with modulus=4, load and en both 1 -> count=4, tc=0, ovf unchanged; the next up step wraps to 0 and pulses tc.
- ovf=1, boundary step coincident with clr_ovf=1 -> ovf stays 1; the next cycle with clr_ovf=1 and no event -> ovf=0.
- Counting at count=3, rst pulsed low between edges -> count=0, tc=0, ovf=0 immediately; counting resumes from 0 after release.
- With `PARAM_COUNTER_PRESCALE_EN` defined, PRESCALE=4, en=1 -> count increments every 4th cycle; en low for 2 cycles mid-interval delays the next step by 2 cycles.

Source files
------------

// File: rtl/param_counter_if.sv
// Control and status bundle for param_counter; master drives controls, slave owns the counter.
// No valid/ready: every control is level-sampled on each rising clk edge and every status output is valid on every cycle.
interface param_counter_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic             up_dn;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] modulus;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_dn, sat, load, load_val, modulus, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up_dn, sat, load, load_val, modulus, clr_ovf,
    output count, tc, ovf
  );
endinterface

// File: rtl/param_counter.sv
// Up/down counter over 0..modulus with load, wrap/saturate, tc pulse and sticky ovf.
// Optional step prescaler enabled by defining PARAM_COUNTER_PRESCALE_EN.
module param_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input logic           clk,
  input logic           rst,
  param_counter_if.slave bus
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_due;
  logic             at_boundary;

  if (WIDTH < 1 || PRESCALE < 1) begin : g_bad_params
  end

`ifdef PARAM_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // Only enabled cycles advance the prescaler; the wrap cycle is the step cycle.
  always_comb begin
    pre_d    = pre_q;
    step_due = 1'b0;
    if (bus.load) begin
      pre_d = '0;
    end else if (bus.en) begin
      if (pre_q == PRE_LAST) begin
        pre_d    = '0;
        step_due = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign step_due = bus.en;
`endif

  // Up uses >= so a count parked above a lowered modulus still counts as the boundary.
  assign at_boundary = bus.up_dn ? (count_q >= bus.modulus) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~bus.clr_ovf;
    if (bus.load) begin
      count_d = (bus.load_val > bus.modulus) ? bus.modulus : bus.load_val;
    end else if (step_due) begin
      if (at_boundary) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (bus.up_dn) begin
          count_d = bus.sat ? bus.modulus : '0;
        end else begin
          count_d = bus.sat ? '0 : bus.modulus;
        end
      end else begin
        count_d = bus.up_dn ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter (WIDTH=3, PRESCALE=4): driver pushes expected
// {count,tc,ovf} per cycle, monitor pops and compares one cycle later.
module tb_param_counter;
  localparam int W  = 3;
  localparam int EW = W + 2;

  logic clk;
  logic rst;

  param_counter_if #(.WIDTH(W)) bus ();

  param_counter #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [EW-1:0] exp_q[$];
  int            id_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            vec_id = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one call = one clock edge, with the state expected after it
  task automatic cyc(input logic e, input logic u, input logic s, input logic l,
                     input logic [W-1:0] lv, input logic [W-1:0] m, input logic c,
                     input logic [W-1:0] ec, input logic et, input logic eo);
    @(negedge clk);
    bus.en       = e;
    bus.up_dn    = u;
    bus.sat      = s;
    bus.load     = l;
    bus.load_val = lv;
    bus.modulus  = m;
    bus.clr_ovf  = c;
    exp_q.push_back({ec, et, eo});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got_v;
    int            id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        id    = id_q.pop_front();
        got_v = {bus.count, bus.tc, bus.ovf};
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL vec%0d count/tc/ovf: got %0d/%0d/%0d want %0d/%0d/%0d", id,
                   got_v[EW-1:2], got_v[1], got_v[0], exp_v[EW-1:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.up_dn    = 1'b1;
    bus.sat      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.modulus  = 3'd7;
    bus.clr_ovf  = 1'b0;
    #12;
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_tc", 32'(bus.tc), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;

`ifdef PARAM_COUNTER_PRESCALE_EN
    cyc(0, 1, 0, 1, 0, 7, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 2, 0, 0);
`else
    // free-running up count with wrap at 7
    for (int i = 1; i <= 7; i++) cyc(1, 1, 0, 0, 0, 7, 0, W'(i), 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 0, 1, 1);
    cyc(1, 1, 0, 0, 0, 7, 0, 1, 0, 1);
    cyc(0, 1, 0, 0, 0, 7, 0, 1, 0, 1);
    // set beats clear, then clear alone
    cyc(0, 1, 0, 1, 7, 7, 0, 7, 0, 1);
    cyc(1, 1, 0, 0, 0, 7, 1, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 7, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 7, 0, 0, 0, 0);
    // load clamps to modulus and beats en
    cyc(1, 1, 0, 1, 6, 4, 0, 4, 0, 0);
    cyc(1, 1, 0, 0, 0, 4, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 4, 1, 0, 0, 0);
    // saturating down count
    cyc(0, 0, 1, 1, 2, 5, 0, 2, 0, 0);
    cyc(1, 0, 1, 0, 0, 5, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 5, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 5, 0, 0, 1, 1);
    cyc(1, 0, 1, 0, 0, 5, 0, 0, 1, 1);
    cyc(1, 0, 1, 0, 0, 5, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 0, 5, 0, 0, 0, 1);
    // down wrap to modulus, then normal decrement
    cyc(1, 0, 0, 0, 0, 5, 1, 5, 1, 1);
    cyc(1, 0, 0, 0, 0, 5, 1, 4, 0, 0);
    // count above a lowered modulus
    cyc(0, 0, 0, 1, 7, 7, 0, 7, 0, 0);
    cyc(1, 0, 0, 0, 0, 3, 0, 6, 0, 0);
    cyc(1, 1, 1, 0, 0, 3, 0, 3, 1, 1);
    cyc(1, 1, 1, 0, 0, 3, 0, 3, 1, 1);
    cyc(1, 1, 0, 0, 0, 5, 0, 4, 0, 1);
    // modulus 0: every step is a boundary event
    cyc(0, 1, 0, 1, 5, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 1, 0, 1, 3, 0, 0, 0, 0, 1);
    // count to 3, then asynchronous reset between edges
    cyc(1, 1, 0, 1, 2, 7, 0, 2, 0, 1);
    cyc(1, 1, 0, 0, 0, 7, 0, 3, 0, 1);
    @(posedge clk);
    #2;
    bus.en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("midreset_count", 32'(bus.count), 32'd0);
    chk("midreset_tc", 32'(bus.tc), 32'd0);
    chk("midreset_ovf", 32'(bus.ovf), 32'd0);
    #1;
    rst = 1'b1;
    cyc(1, 1, 0, 0, 0, 7, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 7, 0, 2, 0, 0);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
